// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator controller.
// States, key codes and default sizing live here.
package calc_pkg;

   localparam int WIDTH_DEF   = 14;
   localparam int MAX_VAL_DEF = 9999;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      EVAL    = 2'd2,
      SHOW    = 2'd3
   } state_e;

   localparam logic [3:0] K_DIG_MAX = 4'd9;
   localparam logic [3:0] K_OP0     = 4'd10;
   localparam logic [3:0] K_OP2     = 4'd12;
   localparam logic [3:0] K_EQ      = 4'd13;
   localparam logic [3:0] K_CLR     = 4'd14;
   localparam logic [3:0] K_NOP     = 4'd15;

   typedef enum logic [2:0] {
      KEY_DIG,
      KEY_OP,
      KEY_EQ,
      KEY_CLR,
      KEY_NOP
   } key_kind_e;

   function automatic key_kind_e key_kind(input logic [3:0] c);
      key_kind_e k;
      k = KEY_NOP;
      if (c <= K_DIG_MAX)
         k = KEY_DIG;
      else if (c <= K_OP2)
         k = KEY_OP;
      else if (c == K_EQ)
         k = KEY_EQ;
      else if (c == K_CLR)
         k = KEY_CLR;
      return k;
   endfunction

endpackage

// File: rtl/calc_if.sv
// Keypad handshake plus operand/result bus between
// the controller, the arithmetic brain and the display.
interface calc_if
   import calc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);

   logic             key_valid;
   logic [3:0]       key_code;
   logic             key_ready;
   logic [WIDTH-1:0] first_digit;
   logic [WIDTH-1:0] second_digit;
   logic [1:0]       operation;
   logic [WIDTH-1:0] brain_result;
   logic [WIDTH-1:0] display;
   logic [1:0]       state_o;
   logic             err;

   modport master (
      output key_valid,
      output key_code,
      output brain_result,
      input  key_ready,
      input  first_digit,
      input  second_digit,
      input  operation,
      input  display,
      input  state_o,
      input  err
   );

   modport slave (
      input  key_valid,
      input  key_code,
      input  brain_result,
      output key_ready,
      output first_digit,
      output second_digit,
      output operation,
      output display,
      output state_o,
      output err
   );

endinterface

// File: rtl/calc_dec_accum.sv
// Appends one decimal digit to an operand, holding the
// operand and flagging overflow when it would exceed MAX_VAL.
module dec_accum
   import calc_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int MAX_VAL = MAX_VAL_DEF
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [3:0]       digit_i,
   output logic [WIDTH-1:0] acc_o,
   output logic             ovf_o
);

   localparam int XW = WIDTH + 3;
   localparam logic [XW-1:0] MAXW = XW'(MAX_VAL);

   logic [XW-1:0] wide;

   always_comb begin
      wide = {3'b000, acc_i} * XW'(10)
           + {{(WIDTH-1){1'b0}}, digit_i};
      ovf_o = wide > MAXW;
      acc_o = ovf_o ? acc_i : wide[WIDTH-1:0];
   end

endmodule

// File: rtl/calc_ctrl.sv
// Keypad-driven calculator controller: collects operands,
// hands them to an external brain and shows the result.
module calc_ctrl
   import calc_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int MAX_VAL = MAX_VAL_DEF
) (
   input logic  clk,
   input logic  rst,
   calc_if.slave bus
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] disp_q, disp_d;
   logic [1:0]       op_q, op_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] a_nxt, b_nxt;
   logic             a_ovf, b_ovf;
   logic             key_ok;
   key_kind_e        kind;
   logic [1:0]       key_op;
   logic [WIDTH-1:0] key_dig;

   dec_accum #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_acc_a (
      .acc_i   (a_q),
      .digit_i (bus.key_code),
      .acc_o   (a_nxt),
      .ovf_o   (a_ovf)
   );

   dec_accum #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_acc_b (
      .acc_i   (b_q),
      .digit_i (bus.key_code),
      .acc_o   (b_nxt),
      .ovf_o   (b_ovf)
   );

   always_comb begin
      key_ok  = bus.key_valid && (state_q != EVAL);
      kind    = key_kind(bus.key_code);
      key_op  = 2'(bus.key_code - K_OP0);
      key_dig = {{(WIDTH-4){1'b0}}, bus.key_code};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      op_d    = op_q;
      err_d   = err_q;
      if (state_q == EVAL) begin
         res_d   = bus.brain_result;
         err_d   = err_q | (bus.brain_result > MAXV);
         state_d = SHOW;
      end else if (key_ok) begin
         unique case (1'b1)
            kind == KEY_CLR: begin
               a_d     = '0;
               b_d     = '0;
               res_d   = '0;
               op_d    = '0;
               err_d   = 1'b0;
               state_d = ENTER_A;
            end
            kind == KEY_DIG: begin
               if (state_q == ENTER_A) begin
                  a_d   = a_nxt;
                  err_d = err_q | a_ovf;
               end else if (state_q == ENTER_B) begin
                  b_d   = b_nxt;
                  err_d = err_q | b_ovf;
               end else begin
                  a_d     = key_dig;
                  b_d     = '0;
                  err_d   = 1'b0;
                  state_d = ENTER_A;
               end
            end
            kind == KEY_OP: begin
               op_d = key_op;
               if (state_q != ENTER_B) begin
                  b_d     = '0;
                  state_d = ENTER_B;
               end
               if (state_q == SHOW)
                  a_d = res_q;
            end
            kind == KEY_EQ: begin
               // SHOW re-runs the last op on the previous result
               if (state_q == ENTER_B) begin
                  state_d = EVAL;
               end else if (state_q == SHOW) begin
                  a_d     = res_q;
                  state_d = EVAL;
               end
            end
            default: ;
         endcase
      end
      unique case (state_d)
         ENTER_A: disp_d = a_d;
         ENTER_B: disp_d = b_d;
         default: disp_d = res_d;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ENTER_A;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         op_q    <= '0;
         err_q   <= 1'b0;
         disp_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         op_q    <= op_d;
         err_q   <= err_d;
         disp_q  <= disp_d;
      end
   end

   assign bus.key_ready    = (state_q != EVAL);
   assign bus.first_digit  = a_q;
   assign bus.second_digit = b_q;
   assign bus.operation    = op_q;
   assign bus.display      = disp_q;
   assign bus.state_o      = state_q;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl with a scoreboard queue
// and a negedge monitor; the bench also plays the brain.
module tb_calc_ctrl;
   import calc_pkg::*;

   localparam int W = 14;

   typedef struct {
      int          cyc;
      string       name;
      logic [1:0]  st;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]  op;
      logic [W-1:0] disp;
      logic        err;
      logic        rdy;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   calc_if #(.WIDTH(W)) bus ();

   calc_ctrl #(.WIDTH(W), .MAX_VAL(9999)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // brain: 0 add, 1 multiply, 2 subtract (all modulo 2^W)
   always_comb begin
      case (bus.operation)
         2'd0:    bus.brain_result = bus.first_digit + bus.second_digit;
         2'd1:    bus.brain_result = W'(bus.first_digit * bus.second_digit);
         2'd2:    bus.brain_result = bus.first_digit - bus.second_digit;
         default: bus.brain_result = '0;
      endcase
   end

   task automatic step(input bit v, input logic [3:0] c, input string nm,
                       input logic [1:0] st, input int a, input int b,
                       input logic [1:0] op, input int disp,
                       input logic er, input logic rdy);
      exp_t e;
      @(negedge clk);
      bus.key_valid = v;
      bus.key_code  = c;
      e.cyc  = cyc + 1;
      e.name = nm;
      e.st   = st;
      e.a    = W'(a);
      e.b    = W'(b);
      e.op   = op;
      e.disp = W'(disp);
      e.err  = er;
      e.rdy  = rdy;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (e.cyc != cyc || bus.state_o !== e.st
             || bus.first_digit !== e.a || bus.second_digit !== e.b
             || bus.operation !== e.op || bus.display !== e.disp
             || bus.err !== e.err || bus.key_ready !== e.rdy) begin
            errors++;
            $display("FAIL %s: got st=%0d a=%0d b=%0d op=%0d disp=%0d err=%0d rdy=%0d want st=%0d a=%0d b=%0d op=%0d disp=%0d err=%0d rdy=%0d",
                     e.name, bus.state_o, bus.first_digit, bus.second_digit,
                     bus.operation, bus.display, bus.err, bus.key_ready,
                     e.st, e.a, e.b, e.op, e.disp, e.err, e.rdy);
         end
      end
   end

   initial begin
      bus.key_valid = 1'b0;
      bus.key_code  = K_NOP;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      step(0, K_NOP, "reset",   0, 0,  0, 0, 0,  0, 1);

      step(1, 4'd1,  "dig1",    0, 1,  0, 0, 1,  0, 1);
      step(1, 4'd0,  "dig10",   0, 10, 0, 0, 10, 0, 1);
      step(1, 4'd11, "op1",     1, 10, 0, 1, 0,  0, 1);
      step(1, 4'd5,  "b5",      1, 10, 5, 1, 5,  0, 1);
      step(1, K_EQ,  "eval1",   2, 10, 5, 1, 0,  0, 0);
      step(0, K_NOP, "show50",  3, 10, 5, 1, 50, 0, 1);

      step(1, 4'd12, "show_op", 1, 50, 0, 2, 0,  0, 1);
      step(1, 4'd2,  "b2",      1, 50, 2, 2, 2,  0, 1);
      step(1, K_EQ,  "eval2",   2, 50, 2, 2, 50, 0, 0);
      step(0, K_NOP, "show48",  3, 50, 2, 2, 48, 0, 1);
      step(1, K_EQ,  "repeat",  2, 48, 2, 2, 48, 0, 0);
      step(0, K_NOP, "show46",  3, 48, 2, 2, 46, 0, 1);
      step(1, K_NOP, "nop",     3, 48, 2, 2, 46, 0, 1);
      step(1, 4'd7,  "show_dig",0, 7,  0, 2, 7,  0, 1);
      step(1, K_CLR, "clr1",    0, 0,  0, 0, 0,  0, 1);

      step(1, 4'd9,  "n9",      0, 9,    0, 0, 9,    0, 1);
      step(1, 4'd9,  "n99",     0, 99,   0, 0, 99,   0, 1);
      step(1, 4'd9,  "n999",    0, 999,  0, 0, 999,  0, 1);
      step(1, 4'd9,  "n9999",   0, 9999, 0, 0, 9999, 0, 1);
      step(1, 4'd9,  "ovf",     0, 9999, 0, 0, 9999, 1, 1);
      step(1, 4'd3,  "ovf_hold",0, 9999, 0, 0, 9999, 1, 1);
      step(1, K_CLR, "clr2",    0, 0,    0, 0, 0,    0, 1);

      step(1, 4'd1,  "a1",      0, 1, 0, 0, 1, 0, 1);
      step(1, K_EQ,  "eq_in_a", 0, 1, 0, 0, 1, 0, 1);
      step(1, 4'd10, "op0",     1, 1, 0, 0, 0, 0, 1);
      step(1, 4'd12, "op2",     1, 1, 0, 2, 0, 0, 1);
      step(1, 4'd2,  "b2b",     1, 1, 2, 2, 2, 0, 1);
      step(1, K_EQ,  "eval3",   2, 1, 2, 2, 0, 0, 0);
      step(0, K_NOP, "res_ovf", 3, 1, 2, 2, 16383, 1, 1);
      step(1, 4'd10, "sticky",  1, 16383, 0, 0, 0, 1, 1);
      step(1, K_CLR, "clr3",    0, 0, 0, 0, 0, 0, 1);

      step(1, 4'd1,  "r_a1",    0, 1, 0, 0, 1, 0, 1);
      step(1, 4'd10, "r_op0",   1, 1, 0, 0, 0, 0, 1);
      step(1, 4'd2,  "r_b2",    1, 1, 2, 0, 2, 0, 1);
      step(1, K_EQ,  "r_eval",  2, 1, 2, 0, 0, 0, 0);
      @(negedge clk);
      bus.key_valid = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      step(0, K_NOP, "rst_eval",  0, 0, 0, 0, 0, 0, 1);
      step(0, K_NOP, "rst_idle",  0, 0, 0, 0, 0, 0, 1);

      repeat (5) @(negedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter WIDTH, default 14, operand/result width.
REQ-002 Parameter MAX_VAL, default 9999, largest enterable/displayable value.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 key_valid  in  1  keypad event present.
REQ-006 key_code  in  4  0-9 digit, 10-12 operation 0-2, 13 equals, 14 clear, 15 no-op.
REQ-007 key_ready  out  1  controller accepts a key this cycle.
REQ-008 first_digit  out  WIDTH  operand A to brain.
REQ-009 second_digit  out  WIDTH  operand B to brain.
REQ-010 operation  out  2  op code to brain (0-2; 3 never driven).
REQ-011 brain_result  in  WIDTH  combinational result from brain.
REQ-012 display  out  WIDTH  value to show.
REQ-013 state_o  out  2  current FSM state.
REQ-014 err  out  1  sticky entry/result overflow flag.

Function
REQ-015 States SHALL be ENTER_A=0, ENTER_B=1, EVAL=2, SHOW=3.
REQ-016 A key SHALL be accepted only on a clock edge with key_valid && key_ready; key_ready SHALL be 0 in EVAL, 1 otherwise.
REQ-017 All effects of an accepted key SHALL be visible on outputs the cycle after acceptance (latency 1).
REQ-018 Digit d in ENTER_A/ENTER_B: active operand <= operand*10+d, computed at WIDTH+3 bits; if sum > MAX_VAL the operand SHALL hold and err SHALL set.
REQ-019 Op key in ENTER_A: operation <= key_code-10, second_digit <= 0, go ENTER_B.
REQ-020 Op key in ENTER_B: operation replaced, operands unchanged, stay ENTER_B.
REQ-021 Equals in ENTER_B SHALL go EVAL; equals in ENTER_A SHALL be ignored.
REQ-022 EVAL SHALL last exactly one cycle: res_reg <= brain_result, err set if brain_result > MAX_VAL, go SHOW.
REQ-023 In SHOW: digit d -> first_digit <= d, second_digit <= 0, err cleared, go ENTER_A.
REQ-024 In SHOW: op key -> first_digit <= res_reg, operation updated, second_digit <= 0, go ENTER_B.
REQ-025 In SHOW: equals -> first_digit <= res_reg, second_digit and operation kept, go EVAL (repeat-last-op).
REQ-026 Clear in ENTER_A/ENTER_B/SHOW SHALL zero operands, operation, res_reg, err and go ENTER_A.
REQ-027 Code 15 SHALL be accepted and ignored in every non-EVAL state.
REQ-028 display SHALL be first_digit in ENTER_A, second_digit in ENTER_B, res_reg in EVAL/SHOW.
REQ-029 first_digit, second_digit, operation, display, err SHALL be registered outputs.
REQ-030 err SHALL stay set until clear or SHOW-state digit.

Reset
REQ-031 rst high SHALL immediately force state ENTER_A and zero first_digit, second_digit, operation, res_reg, display, err; key_ready SHALL be 1.
REQ-032 rst asserted during EVAL SHALL abort evaluation; no result SHALL be captured.

Structure
REQ-033 Package calc_pkg SHALL hold the state enum, key-code constants, WIDTH and MAX_VAL defaults.
REQ-034 Operand append/saturation logic SHALL be one sub-module, dec_accum, used for both operands.
REQ-035 brain SHALL be instantiated beside calc_ctrl at top level, not inside it.

Verification
REQ-036 Reset pulse -> state_o=0, display=0, err=0, key_ready=1.
REQ-037 Keys 1,0,op1,5,= -> first_digit=10, second_digit=5, operation=1, key_ready=0 one cycle, then display=brain_result, state_o=3.
REQ-038 Keys 9,9,9,9,9 -> first_digit=9999, err=1; then clear -> display=0, err=0.
REQ-039 After 10 op1 5 = : op2,2,= -> first_digit=res_reg, operation=2, second_digit=2; then = -> reevaluates with second_digit=2.
REQ-040 Keys 1,op0,op2 -> operation=2, first_digit=1; equals in ENTER_A ignored.
REQ-041 rst asserted in EVAL cycle -> state_o=0, display=0 next cycle, no result captured.
